// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared definitions for the 5-stage pipeline control logic.
//           Provides the hazard-controller FSM state type, the default
//           configuration values and the pipeline-register index constants.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Default configuration.
  localparam int REG_ADDR_W_DEF = 5;
  localparam int MC_CYCLES_DEF  = 4;

  // Index of the register that feeds each stage: PC feeds IF, IF/ID feeds
  // ID, and so on. Used to address the internal write-enable/flush vectors.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NUM_STG = 5;

  // Hazard-controller FSM state.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
// ============================================================================
// Module  : pipe_hazard_detect
// Purpose : Purely combinational detection of load-use and data-memory
//           wait-state hazards. Shared with the forwarding unit.
// Ports   : i_id_rs1/i_id_rs2 - source registers of the ID instruction
//           i_ex_rd           - destination register of the EX instruction
//           i_ex_mem_read     - EX instruction is a load
//           i_dmem_req        - MEM stage has an outstanding access
//           i_dmem_ack        - data memory completes the access this cycle
//           o_loaduse         - ID needs the result of the load in EX
//           o_memstall        - MEM stage is waiting on data memory
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ack,
  output logic                  o_loaduse,
  output logic                  o_memstall
);

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign o_loaduse = i_ex_mem_read & (i_ex_rd != '0) &
                     ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

  assign o_memstall = i_dmem_req & ~i_dmem_ack;

endmodule : pipe_hazard_detect

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Central stall/flush generator for the IF/ID/EX/MEM/WB pipeline.
//           Drives active-low write enables and active-high flushes of the PC
//           and every pipeline register. Resolves memory wait states,
//           multi-cycle EX ops, taken branches and load-use hazards, in that
//           priority order.
// Ports   : clk, rst                   - clock, synchronous active-high reset
//           id_rs1, id_rs2, ex_rd      - register addresses for load-use check
//           ex_mem_read                - EX instruction is a load
//           ex_branch_taken            - EX branch/jump resolved taken
//           ex_mc_start                - EX instruction is a multi-cycle op
//           dmem_req, dmem_ack         - data-memory handshake
//           nwen_*                     - active-low write enables
//           flush_*                    - bubble-insert controls
//           mc_busy                    - multi-cycle op occupies EX
//           stall_cnt, flush_cnt       - performance counters (HAZ_PERF_EN)
// Config  : define HAZ_PERF_EN to add the stall/flush performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_CYCLES  = MC_CYCLES_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  nwen_pc,
  output logic                  nwen_ifid,
  output logic                  nwen_idex,
  output logic                  nwen_exmem,
  output logic                  nwen_memwb,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic                  flush_memwb,
  output logic                  mc_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam logic [MC_CNT_W-1:0] C_CNT_LOAD = MC_CNT_W'(MC_CYCLES - 2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MC_CNT_W-1:0]   r_cnt;
  logic [MC_CNT_W-1:0]   w_cnt_nxt;

  logic                  w_loaduse;
  logic                  w_memstall;
  logic                  w_mc_busy;
  logic                  w_mcstall;
  logic                  w_mc_last;
  logic [NUM_STG-1:0]    w_nwen;
  logic [NUM_STG-1:0]    w_flush;

  pipe_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .i_dmem_req    (dmem_req),
    .i_dmem_ack    (dmem_ack),
    .o_loaduse     (w_loaduse),
    .o_memstall    (w_memstall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_nwen      = '0;
    w_flush     = '0;

    // The final EX cycle of a multi-cycle op is busy but no longer stalls:
    // the op's result moves on to MEM at the end of this cycle.
    w_mc_last = (r_state == MC_BUSY) && (r_cnt == '0);
    w_mc_busy = ~rst & ((r_state == MC_BUSY) | ((r_state == RUN) & ex_mc_start));
    w_mcstall = w_mc_busy & ~w_mc_last;

    // Next-state: a memory stall freezes the whole pipe, including EX, so
    // the FSM and counter hold for its duration.
    if (!w_memstall) begin
      case (r_state)
        RUN: begin
          if (ex_mc_start) begin
            w_state_nxt = MC_BUSY;
            w_cnt_nxt   = C_CNT_LOAD;
          end
        end
        MC_BUSY: begin
          if (r_cnt == '0) begin
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt - MC_CNT_W'(1);
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end

    if (rst) begin
      w_flush = '1;
    end else if (w_memstall) begin
      w_nwen = '1;
    end else if (w_mcstall) begin
      w_nwen[STG_IF]   = 1'b1;
      w_nwen[STG_ID]   = 1'b1;
      w_nwen[STG_EX]   = 1'b1;
      w_flush[STG_MEM] = 1'b1;
    end else if (ex_branch_taken) begin
      // Squashing ID also discards any load-use hazard it would have raised.
      w_flush[STG_ID] = 1'b1;
      w_flush[STG_EX] = 1'b1;
    end else if (w_loaduse) begin
      w_nwen[STG_IF]  = 1'b1;
      w_nwen[STG_ID]  = 1'b1;
      w_flush[STG_EX] = 1'b1;
    end
  end

  assign nwen_pc     = w_nwen[STG_IF];
  assign nwen_ifid   = w_nwen[STG_ID];
  assign nwen_idex   = w_nwen[STG_EX];
  assign nwen_exmem  = w_nwen[STG_MEM];
  assign nwen_memwb  = w_nwen[STG_WB];
  assign flush_ifid  = w_flush[STG_ID];
  assign flush_idex  = w_flush[STG_EX];
  assign flush_exmem = w_flush[STG_MEM];
  assign flush_memwb = w_flush[STG_WB];
  assign mc_busy     = w_mc_busy;

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_branch_flush;

  // Only flushes caused by a redirect count; reset also drives flush_ifid.
  assign w_branch_flush = ~rst & ~w_memstall & ~w_mcstall & ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_nwen[STG_IF]) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_branch_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule : pipe_hazard_ctrl

`default_nettype wire
